pipe_ctrl: RTL and testbench

//  Pipeline stall/flush controller: the producer of stall_ctrl[5:0], flush and new_pc, which every pipe_reg_* consumes.

---
 rtl/pipe_ctrl_pkg.sv | 52 +++++
 rtl/pipe_ctrl_watchdog.sv | 47 ++++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants for the pipeline stall/flush controller:
//               stall masks, exception codes and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // stall_ctrl bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [5:0] STALL_MASK_NONE = 6'b000000;
    localparam logic [5:0] STALL_MASK_IF   = 6'b000011;
    localparam logic [5:0] STALL_MASK_ID   = 6'b000111;
    localparam logic [5:0] STALL_MASK_EX   = 6'b001111;
    localparam logic [5:0] STALL_MASK_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000A;
    localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000E;

    typedef enum logic [0:0] {
        PCTRL_IDLE     = 1'b0,
        PCTRL_FLUSHING = 1'b1
    } pctrl_state_t;

    // The deepest requesting stage decides how much of the front end is held.
    function automatic logic [5:0] stall_mask(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] mask;
        mask = STALL_MASK_NONE;
        if (req_mem) begin
            mask = STALL_MASK_MEM;
        end else if (req_ex) begin
            mask = STALL_MASK_EX;
        end else if (req_id) begin
            mask = STALL_MASK_ID;
        end else if (req_if) begin
            mask = STALL_MASK_IF;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_watchdog
// Description : Counts consecutive stalled cycles (saturating) and raises a
//               sticky timeout flag once STALL_TIMEOUT is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_watchdog #(
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic stall_timeout
);

    localparam int c_cnt_w = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit    = c_cnt_w'(STALL_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_limit_m1 = c_cnt_w'(STALL_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_wd_cnt;
    logic               r_timeout;
    logic               w_hit;

    // This stalled cycle is the one that brings the count up to the limit.
    assign w_hit = stalled && (r_wd_cnt >= c_limit_m1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!stalled) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_limit) begin
                r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
            end
            if (w_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush controller. Merges stage stall requests
//               with MEM-stage exceptions/ERET, redirects the PC and runs a
//               stall watchdog. Optional macro PIPE_CTRL_PERF_EN adds
//               perf_stall_cycles / perf_flush_count counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] mem_except_type,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall_ctrl,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    // Event cycle is the first flush cycle, so FLUSHING covers the remaining ones.
    localparam logic [3:0] c_cnt_load = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam bit         c_multi    = (FLUSH_CYCLES > 1);

    pctrl_state_t r_state;
    pctrl_state_t w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic [31:0]  r_new_pc_q;
    logic [31:0]  w_redirect;
    logic         w_exc_valid;
    logic         w_event;

    assign w_exc_valid = (mem_except_type != EXC_NONE);
    assign w_redirect  = (mem_except_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;

    // Outputs are gated by rst so an asserted reset silences them immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_event     = 1'b0;
        stall_ctrl  = STALL_MASK_NONE;
        flush       = 1'b0;
        new_pc      = 32'h0000_0000;
        case (r_state)
            PCTRL_IDLE: begin
                if (rst && w_exc_valid) begin
                    w_event = 1'b1;
                    flush   = 1'b1;
                    new_pc  = w_redirect;
                    if (c_multi) begin
                        w_state_nxt = PCTRL_FLUSHING;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end else if (rst) begin
                    stall_ctrl = stall_mask(stallreq_if, stallreq_id,
                                            stallreq_ex, stallreq_mem);
                end
            end
            PCTRL_FLUSHING: begin
                flush  = rst;
                new_pc = rst ? r_new_pc_q : 32'h0000_0000;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = PCTRL_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = PCTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= PCTRL_IDLE;
            r_cnt      <= 4'd0;
            r_new_pc_q <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_event) begin
                r_new_pc_q <= w_redirect;
            end
        end
    end

    pipe_ctrl_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stalled       (stall_ctrl != STALL_MASK_NONE),
        .stall_timeout (stall_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= 32'h0000_0000;
            r_perf_flush <= 32'h0000_0000;
        end else begin
            if ((stall_ctrl != STALL_MASK_NONE) && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_event && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl; two instances (1-cycle and
//               3-cycle flush) share stimulus and are checked against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
    logic [31:0] exc = 32'h0, epc = 32'h0;

    logic [5:0]  got_stall [2];
    logic        got_flush [2];
    logic [31:0] got_npc   [2];
    logic        got_to    [2];
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] got_pstall [2];
    logic [31:0] got_pflush [2];
`endif

    int          total = 0;
    int          bad   = 0;

    int          cfg_fc [2] = '{1, 3};
    int          cfg_to [2] = '{8, 5};

    int          m_left [2];
    int          m_run  [2];
    bit          m_to   [2];
    logic [31:0] m_hold [2];
    longint      m_pstall [2];
    longint      m_pflush [2];

    logic [5:0]  exp_stall [2];
    logic        exp_flush [2];
    logic [31:0] exp_npc   [2];

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(1), .STALL_TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .stallreq_if(req_if), .stallreq_id(req_id), .stallreq_ex(req_ex), .stallreq_mem(req_mem),
        .mem_except_type(exc), .cp0_epc(epc),
        .stall_ctrl(got_stall[0]), .flush(got_flush[0]), .new_pc(got_npc[0]),
        .stall_timeout(got_to[0])
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cycles(got_pstall[0]), .perf_flush_count(got_pflush[0])
`endif
    );

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(3), .STALL_TIMEOUT(5)) u_dut_b (
        .clk(clk), .rst(rst),
        .stallreq_if(req_if), .stallreq_id(req_id), .stallreq_ex(req_ex), .stallreq_mem(req_mem),
        .mem_except_type(exc), .cp0_epc(epc),
        .stall_ctrl(got_stall[1]), .flush(got_flush[1]), .new_pc(got_npc[1]),
        .stall_timeout(got_to[1])
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cycles(got_pstall[1]), .perf_flush_count(got_pflush[1])
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_run[i] = 0; m_to[i] = 1'b0; m_hold[i] = 32'h0;
            m_pstall[i] = 0; m_pflush[i] = 0;
        end
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic compute_exp();
        int level;
        level = req_mem ? 5 : req_ex ? 4 : req_id ? 3 : req_if ? 2 : 0;
        for (int i = 0; i < 2; i++) begin
            exp_stall[i] = 6'd0; exp_flush[i] = 1'b0; exp_npc[i] = 32'h0;
            if (m_left[i] > 0) begin
                exp_flush[i] = 1'b1; exp_npc[i] = m_hold[i];
            end else if (exc != 32'h0) begin
                exp_flush[i] = 1'b1;
                exp_npc[i]   = (exc == EXC_ERET) ? epc : 32'h0000_0020;
            end else begin
                exp_stall[i] = 6'((1 << level) - 1);
            end
        end
    endtask

    task automatic drive(input bit f, input bit d, input bit e, input bit m,
                         input logic [31:0] x, input logic [31:0] p);
        @(negedge clk);
        req_if = f; req_id = d; req_ex = e; req_mem = m; exc = x; epc = p;
        compute_exp();
        #1;
    endtask

    // Advances one clock and moves the model forward with that cycle's inputs.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_left[i] > 0) begin
                m_left[i]--;
            end else if (exc != 32'h0) begin
                m_left[i] = cfg_fc[i] - 1;
                m_hold[i] = exp_npc[i];
                m_pflush[i]++;
            end
            if (exp_stall[i] != 6'd0) begin
                m_run[i] = (m_run[i] + 1 > cfg_to[i]) ? cfg_to[i] : m_run[i] + 1;
                m_pstall[i]++;
            end else begin
                m_run[i] = 0;
            end
            if (m_run[i] >= cfg_to[i]) m_to[i] = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0; exc = 0; epc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_mem = 1'b1; req_ex = 1'b1; exc = 32'h1; epc = 32'h44;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({got_stall[i], got_flush[i], got_npc[i], got_to[i]} !== 40'h0) begin
                bad++;
                $display("FAIL reset inst%0d: got stall=%b flush=%b pc=%h to=%b, want all zero",
                         i, got_stall[i], got_flush[i], got_npc[i], got_to[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1; req_mem = 0; req_ex = 0; exc = 0; epc = 0;
    endtask

    task automatic test_stall_priority();
        bit pat [6][4] = '{'{0,1,1,0}, '{1,0,0,0}, '{1,1,0,0}, '{0,0,1,0}, '{1,1,1,1}, '{0,0,0,0}};
        for (int k = 0; k < 6; k++) begin
            drive(pat[k][0], pat[k][1], pat[k][2], pat[k][3], 32'h0, 32'h0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({got_stall[i], got_flush[i], got_npc[i]} !== {exp_stall[i], exp_flush[i], exp_npc[i]}) begin
                    bad++;
                    $display("FAIL stall_prio p%0d inst%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                             k, i, got_stall[i], got_flush[i], got_npc[i], exp_stall[i], exp_flush[i], exp_npc[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_exception();
        logic [31:0] xs [4] = '{32'h1, EXC_ERET, 32'h0, 32'h0};
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, k == 0, xs[k], 32'h0000_1234);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({got_stall[i], got_flush[i], got_npc[i]} !== {exp_stall[i], exp_flush[i], exp_npc[i]}) begin
                    bad++;
                    $display("FAIL exception c%0d inst%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                             k, i, got_stall[i], got_flush[i], got_npc[i], exp_stall[i], exp_flush[i], exp_npc[i]);
                end
            end
            tick();
        end
        repeat (4) begin
            drive(0, 0, 0, 0, 32'h0, 32'h0);
            tick();
        end
    endtask

    task automatic test_eret();
        drive(0, 1, 0, 0, EXC_ERET, 32'h0000_1234);
        total++;
        if ({got_flush[0], got_npc[0], got_stall[0]} !== {1'b1, 32'h0000_1234, 6'd0}) begin
            bad++;
            $display("FAIL eret: got flush=%b pc=%h stall=%b, want flush=1 pc=00001234 stall=000000",
                     got_flush[0], got_npc[0], got_stall[0]);
        end
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        total++;
        if ({got_flush[0], got_npc[0]} !== 33'h0) begin
            bad++;
            $display("FAIL eret_end: got flush=%b pc=%h, want flush=0 pc=00000000", got_flush[0], got_npc[0]);
        end
        tick();
        repeat (3) begin
            drive(0, 0, 0, 0, 32'h0, 32'h0);
            tick();
        end
    endtask

    task automatic test_flush_hold();
        int flush_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, k == 2, (k == 0) ? 32'h1 : (k == 1) ? EXC_ERET : 32'h0, 32'h0000_5554);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({got_stall[i], got_flush[i], got_npc[i]} !== {exp_stall[i], exp_flush[i], exp_npc[i]}) begin
                    bad++;
                    $display("FAIL flush_hold c%0d inst%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                             k, i, got_stall[i], got_flush[i], got_npc[i], exp_stall[i], exp_flush[i], exp_npc[i]);
                end
            end
            if (got_flush[1] === 1'b1) flush_cnt++;
            tick();
        end
        total++;
        if (flush_cnt != 3) begin
            bad++;
            $display("FAIL flush_len: got %0d cycles, want 3", flush_cnt);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int k = 0; k < 11; k++) begin
            drive(0, 0, 0, k < 8, 32'h0, 32'h0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({got_stall[i], got_to[i]} !== {exp_stall[i], m_to[i]}) begin
                    bad++;
                    $display("FAIL watchdog c%0d inst%0d: got stall=%b to=%b, want stall=%b to=%b",
                             k, i, got_stall[i], got_to[i], exp_stall[i], m_to[i]);
                end
            end
            tick();
            if (k == 6 || k == 7 || k == 10) begin
                total++;
                if (got_to[0] !== (k != 6)) begin
                    bad++;
                    $display("FAIL timeout_edge after %0d cycles: got %b, want %b", k + 1, got_to[0], k != 6);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] codes [4] = '{32'h1, EXC_SYSCALL, EXC_ERET, EXC_OVERFLOW};
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 3)] : 32'h0,
                  $urandom & 32'hFFFF_FFFC);
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({got_stall[i], got_flush[i], got_npc[i], got_to[i]} !==
                    {exp_stall[i], exp_flush[i], exp_npc[i], m_to[i]}) begin
                    bad++;
                    $display("FAIL random c%0d inst%0d: got stall=%b flush=%b pc=%h to=%b, want stall=%b flush=%b pc=%h to=%b",
                             k, i, got_stall[i], got_flush[i], got_npc[i], got_to[i],
                             exp_stall[i], exp_flush[i], exp_npc[i], m_to[i]);
                end
            end
            tick();
        end
`ifdef PIPE_CTRL_PERF_EN
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({got_pstall[i], got_pflush[i]} !== {32'(m_pstall[i]), 32'(m_pflush[i])}) begin
                bad++;
                $display("FAIL perf inst%0d: got stall_cycles=%0d flush_count=%0d, want %0d %0d",
                         i, got_pstall[i], got_pflush[i], m_pstall[i], m_pflush[i]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_flush();
        drive(0, 0, 1, 0, 32'h1, 32'h0);
        tick();
        drive(0, 0, 1, 0, 32'h0, 32'h0);
        total++;
        if (got_flush[1] !== 1'b1) begin
            bad++;
            $display("FAIL midflush_pre: got flush=%b, want 1", got_flush[1]);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({got_flush[1], got_npc[1], got_stall[1]} !== 39'h0) begin
            bad++;
            $display("FAIL midflush_async: got flush=%b pc=%h stall=%b, want all zero",
                     got_flush[1], got_npc[1], got_stall[1]);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({got_stall[i], got_flush[i], got_npc[i], got_to[i]} !== 40'h0) begin
                bad++;
                $display("FAIL midflush_release inst%0d: got stall=%b flush=%b pc=%h to=%b, want all zero",
                         i, got_stall[i], got_flush[i], got_npc[i], got_to[i]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_exception();
        test_eret();
        test_flush_hold();
        test_watchdog();
        test_random();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
